// File: rtl/mod_cycle_counter_if.sv
// Handshake bundle for mod_cycle_counter.
//   master : drives en, dir, load, load_val; observes count and status outputs
//   slave  : the counter itself; samples the controls, drives count, wrap, tc,
//            load_err, bad, bad_sticky
interface mod_cycle_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             tc;
    logic             load_err;
    logic             bad;
    logic             bad_sticky;

    modport master (
        output en, dir, load, load_val,
        input  count, wrap, tc, load_err, bad, bad_sticky
    );

    modport slave (
        input  en, dir, load, load_val,
        output count, wrap, tc, load_err, bad, bad_sticky
    );
endinterface

// File: rtl/mod_cycle_counter.sv
// Modulo-MODULUS up/down cycle counter with enable and range-checked parallel load.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-low; clears all state
//   bus.en     : step once in direction bus.dir
//   bus.dir    : 0 = up, 1 = down
//   bus.load   : parallel load of bus.load_val (ignored with load_err if >= MODULUS)
//   bus.count  : registered count, always < MODULUS
//   bus.wrap   : registered pulse, high while count shows the value after a wrap
//   bus.tc     : combinational terminal count for the current direction
//   bus.load_err   : registered pulse, high the cycle after an out-of-range load
//   bus.bad        : combinational invariant violation, count >= MODULUS
//   bus.bad_sticky : registered latch of bad, cleared only by reset
module mod_cycle_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_cycle_counter_if.slave   bus
);

    localparam longint unsigned FullRange = 64'd1 << WIDTH;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_cycle_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > FullRange) begin : g_bad_modulus
        $error("mod_cycle_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q;
    logic             load_err_d, load_err_q;
    logic             bad_sticky_d, bad_sticky_q;
    logic             load_legal;
    logic             at_top;
    logic             at_zero;
    logic             bad;

    // Compare at 64 bits so MODULUS = 2**WIDTH never truncates.
    assign load_legal = (64'(bus.load_val) < MODULUS);
    assign at_top     = (count_q == MaxCount);
    assign at_zero    = (count_q == '0);

    if (MODULUS == FullRange) begin : g_bad_full
        assign bad = 1'b0;
    end else begin : g_bad_partial
        assign bad = (64'(count_q) >= MODULUS);
    end

    always_comb begin
        count_d      = count_q;
        wrap_d       = 1'b0;
        load_err_d   = 1'b0;
        bad_sticky_d = bad_sticky_q | bad;
        if (bus.load) begin
            // A rejected load still suppresses the enable for this cycle.
            if (load_legal) begin
                count_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (!bus.dir) begin
                if (at_top) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_d = MaxCount;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q      <= '0;
            wrap_q       <= 1'b0;
            load_err_q   <= 1'b0;
            bad_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            load_err_q   <= load_err_d;
            bad_sticky_q <= bad_sticky_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.wrap       = wrap_q;
    assign bus.load_err   = load_err_q;
    assign bus.bad_sticky = bad_sticky_q;
    assign bus.bad        = bad;
    assign bus.tc         = bus.dir ? at_zero : at_top;

endmodule

// File: doc/mod_cycle_counter.md
# mod_cycle_counter

Parametrised modulo-N cycle counter with enable, up/down direction, and range-checked parallel load. It exposes a wrap pulse, terminal-count flag and an invariant-violation output `bad`. `bad` is the safety property for the formal flow, and every legal run must keep it at 0. The block is the generalised successor of the fixed 2-bit 0→1→2→0 cycle, and is used as both a design building block and a model-checking target.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..32.
- `MODULUS`, default 12: count sequence length. Legal range 2..2^WIDTH. Elaboration fails outside this range.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. When 0 at a rising edge of `clk`, all state is cleared.
- `en` in 1: advance count by one step in direction `dir`.
- `dir` in 1: 0 = count up, 1 = count down; sampled only when `en`=1.
- `load` in 1: parallel-load request.
- `load_val` in WIDTH: value to load; legal only when < MODULUS.
- `count` out WIDTH: current count, registered.
- `wrap` out 1: registered one-cycle pulse, high in the cycle in which `count` shows the value just after a wrap.
- `tc` out 1: combinational terminal count. High when (`dir`=0 and `count`=MODULUS-1) or (`dir`=1 and `count`=0).
- `load_err` out 1: registered one-cycle pulse, high in the cycle after an out-of-range load request.
- `bad` out 1: combinational, `count` ≥ MODULUS. It is a constant 0 when MODULUS = 2^WIDTH.
- `bad_sticky` out 1: registered and sticky. It is set once `bad` has been seen high at a clock edge and is cleared only by reset.

## Operation
- **Priority at each edge:** reset > load > en > hold.
- **Reset:**
  - Happens when `reset`=0 at the edge.
  - `count`=0, `wrap`=0, `load_err`=0, `bad_sticky`=0.
  - It takes effect regardless of `load`/`en`, including mid-sequence.
- **Load with `load_val` < MODULUS:**
  - `count` ← `load_val`.
  - `wrap`=0 and `load_err`=0 next cycle.
  - `en` is ignored that cycle.
- **Load with `load_val` ≥ MODULUS:**
  - `count` holds, and `en` is also ignored that cycle.
  - `load_err`=1 for exactly the next cycle.
  - `wrap`=0.
- **Enable, up (`dir`=0):**
  - `count` ← `count`+1 if `count` < MODULUS-1.
  - Otherwise `count` ← 0 and `wrap`=1 next cycle.
- **Enable, down (`dir`=1):**
  - `count` ← `count`-1 if `count` > 0.
  - Otherwise `count` ← MODULUS-1 and `wrap`=1 next cycle.
- **Hold (no load, no en):** `count` unchanged, `wrap`=0, `load_err`=0.
- **Arithmetic:** compare and increment at WIDTH bits with no intermediate overflow. When MODULUS = 2^WIDTH, wrap occurs at all-ones ↔ 0.
- **`bad`:**
  - Unreachable by construction, because all next-state values are < MODULUS.
  - `bad_sticky` latches it so that bench checks and formal assertions can observe a violation after the fact.
- **State space:** `count` visits exactly MODULUS values. No don't-care states may be added, for example through encoding.

## Timing
- `count`, `wrap`, `load_err` and `bad_sticky` are all registered, with 1-cycle latency from the sampling edge.
- `tc` and `bad` are combinational from `count` (and `dir` for `tc`), with zero latency.
- **Reset values:** `count`=0, `wrap`=0, `load_err`=0, `bad_sticky`=0. Consequently `tc`=1 if `dir`=1 and 0 if `dir`=0, and `bad`=0.
- **Back-to-back enables:** one step per cycle.
- **Wrap spacing:** with MODULUS=2 and `en` held high, `wrap` pulses every other cycle.
- **Direction changes:** `dir` may change every cycle. Each edge uses the `dir` sampled at that edge.
- **Load and enable together:** `load` and `en` in the same cycle, with a legal value, leave `count` = `load_val` and produce no increment.

## Test plan
1. **Reset and count up.** Hold `reset`=0 for 2 cycles, then release, with WIDTH=4, MODULUS=12, `en`=1, `dir`=0.
   - `count` goes 0,1,…,11,0.
   - `wrap`=1 only in the cycle showing 0 after 11.
   - `tc`=1 while `count`=11.
2. **Count down.** From `count`=0, apply `en`=1, `dir`=1 for 3 cycles.
   - `count` goes 11, 10, 9.
   - `wrap`=1 only with the first 11.
   - `tc`=1 at `count`=0.
3. **Load legal and illegal.**
   - `load`=1 with `load_val`=5, plus `en`=1 → `count`=5, `load_err`=0.
   - Then `load_val`=13 → `count` stays 5 and `load_err`=1 for one cycle.
   - Then `load_val`=11 with `en`=1 in the next cycle → `count`=11, then 0, with `wrap`.
4. **Hold and reset mid-count.**
   - `en`=0 for 4 cycles at `count`=7 → `count` stays 7, `wrap`=0.
   - Then `reset`=0 together with `load`=1, `load_val`=3 → `count`=0 and all pulses 0.
5. **Full-range modulus.**
   - WIDTH=2, MODULUS=4, up → `count` goes 0,1,2,3,0 with `wrap` at 0.
   - `bad` stays constant 0.
   - Loading 3 is accepted.
6. **Invariant.** Run 10k random cycles of `en`/`dir`/`load`/`load_val` against a reference model, with MODULUS=12.
   - `count` matches the model every cycle.
   - `bad`=0 and `bad_sticky`=0 throughout.
